// File: rtl/device_req_arbiter_pkg.sv
// device_req_arbiter_pkg: shared arbiter state type and default timing constants
package device_req_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_GAP} arb_state_t;
  localparam int DEV_TIMEOUT_DEF = 32;
  localparam int DEV_GAP_DEF = 2;
endpackage

// File: rtl/device_req_arbiter_if.sv
// device_req_arbiter_if: device request/grant bus plus the router DeviceReq/DeviceResp pair
//   dev_req     device -> arbiter, request level per device
//   dev_grant   arbiter -> device, one-hot ownership of the router
//   dev_ack     arbiter -> device, one-cycle response-delivered pulse
//   dev_timeout arbiter -> device, one-cycle grant-aborted pulse
//   DeviceReq   arbiter -> router, request level
//   DeviceResp  router -> arbiter, response pulse
interface device_req_arbiter_if #(parameter int N_DEV = 4);
  logic [N_DEV-1:0] dev_req;
  logic [N_DEV-1:0] dev_grant;
  logic [N_DEV-1:0] dev_ack;
  logic [N_DEV-1:0] dev_timeout;
  logic DeviceReq;
  logic DeviceResp;
  modport master (input dev_req, DeviceResp, output dev_grant, dev_ack, dev_timeout, DeviceReq);
  modport slave (output dev_req, DeviceResp, input dev_grant, dev_ack, dev_timeout, DeviceReq);
endinterface

// File: rtl/device_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request after i_last (wrapping)
//   i_req    request vector
//   i_last   index of the previous winner
//   o_found  some request is set
//   o_idx    winning index
//   o_onehot winning index as a one-hot vector (zero when nothing found)
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_found,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction
  always_comb begin
    o_found = 1'b0;
    o_idx = '0;
    for (int k = 1; k <= N; k++)
      if (!o_found && i_req[wrap(int'(i_last) + k)]) begin
        o_found = 1'b1;
        o_idx = wrap(int'(i_last) + k);
      end
  end
  assign o_onehot = o_found ? N'(1) << o_idx : '0;
endmodule

// File: rtl/device_req_arbiter.sv
// device_req_arbiter: round-robin arbiter sharing one router DeviceReq among N_DEV devices
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    device_req_arbiter_if.master (device request/grant/ack/timeout, router req/resp)
module device_req_arbiter
  import device_req_arbiter_pkg::*;
#(
  parameter int N_DEV = 4,
  parameter int TIMEOUT = DEV_TIMEOUT_DEF,
  parameter int GAP_CYC = DEV_GAP_DEF
) (
  input logic clk,
  input logic reset,
  device_req_arbiter_if.master bus
);
  localparam int IW = $clog2(N_DEV);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYC + 1);
  arb_state_t r_state;
  logic [TW-1:0] r_timer;
  logic [GW-1:0] r_gap;
  logic [IW-1:0] r_last;
  logic [N_DEV-1:0] r_grant, r_ack, r_timeout;
  logic r_dreq;
  logic w_found;
  logic [IW-1:0] w_idx;
  logic [N_DEV-1:0] w_onehot;
  logic w_resp, w_keep, w_expired;
  rr_pick #(.N(N_DEV)) u_pick (
    .i_req(bus.dev_req),
    .i_last(r_last),
    .o_found(w_found),
    .o_idx(w_idx),
    .o_onehot(w_onehot)
  );
  // Priority inside GRANT: response, then withdrawal, then expiry.
  assign w_resp = bus.DeviceResp;
  assign w_keep = |(bus.dev_req & r_grant);
  assign w_expired = r_timer == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= ARB_IDLE;
      r_timer <= '0;
      r_gap <= '0;
      r_last <= IW'(N_DEV - 1);
      r_grant <= '0;
      r_ack <= '0;
      r_timeout <= '0;
      r_dreq <= 1'b0;
    end else begin
      r_ack <= '0;
      r_timeout <= '0;
      case (r_state)
        ARB_IDLE:
          if (w_found) begin
            r_state <= ARB_GRANT;
            r_grant <= w_onehot;
            r_dreq <= 1'b1;
            r_last <= w_idx;
            r_timer <= '0;
          end
        ARB_GRANT:
          if (w_resp || !w_keep || w_expired) begin
            r_state <= ARB_GAP;
            r_grant <= '0;
            r_dreq <= 1'b0;
            r_gap <= '0;
            r_ack <= w_resp ? r_grant : '0;
            r_timeout <= (!w_resp && w_keep) ? r_grant : '0;
          end else
            r_timer <= r_timer + 1'b1;
        ARB_GAP:
          if (r_gap == GW'(GAP_CYC - 1))
            r_state <= ARB_IDLE;
          else
            r_gap <= r_gap + 1'b1;
        default: r_state <= ARB_IDLE;
      endcase
    end
  assign bus.dev_grant = r_grant;
  assign bus.dev_ack = r_ack;
  assign bus.dev_timeout = r_timeout;
  assign bus.DeviceReq = r_dreq;
endmodule
